// File: rtl/irqc_pkg.sv
// irqc_pkg: shared constants and types for the
// prioritised interrupt controller.
package irqc_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int GEN_BIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irqc_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: 2-flop synchroniser for one
// request line plus a rising-edge detector.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  // synchronise the line and keep last level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= line;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;

endmodule

// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt front end
// for the cdm16 core with memory-mapped registers.
module irq_controller #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter logic [5:0]  VEC_BASE_RST = 6'h10
) (
  input  logic               input_clock,
  input  logic               in_reset_n,
  input  logic [NUM_IRQ-1:0] irq_lines,
  output logic               irq,
  output logic [5:0]         int_vec,
  input  logic               iack,
  input  logic [15:0]        address,
  input  logic               mem,
  input  logic               data,
  input  logic               read,
  input  logic               word,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata
);

  import irqc_pkg::*;

  logic [NUM_IRQ-1:0] level;
  logic [NUM_IRQ-1:0] rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (input_clock),
      .rst_n (in_reset_n),
      .line  (irq_lines[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edge_mode;
  logic               gen;
  logic [5:0]         vec_base;

  irqc_state_t state;
  logic [3:0]  win_idx;
  logic [5:0]  vec_q;

  logic        sel;
  logic        wr;
  logic [1:0]  reg_sel;
  logic [15:0] be;
  logic [15:0] wd;
  logic        wr_pend;
  logic        wr_mask;
  logic        wr_edge;
  logic        wr_ctrl;

  assign sel = mem & data &
    (address[15:3] == BASE_ADDR[15:3]);
  assign wr      = sel & ~read;
  assign reg_sel = address[2:1];
  assign be      = word ? 16'hFFFF : 16'h00FF;
  assign wd      = wdata & be;

  assign wr_pend = wr & (reg_sel == REG_PENDING);
  assign wr_mask = wr & (reg_sel == REG_MASK);
  assign wr_edge = wr & (reg_sel == REG_EDGE);
  assign wr_ctrl = wr & (reg_sel == REG_CTRL);

  logic [NUM_IRQ-1:0] keep;
  logic [NUM_IRQ-1:0] mask_nxt;
  logic [NUM_IRQ-1:0] edge_nxt;

  assign keep     = ~be[NUM_IRQ-1:0];
  assign mask_nxt = (mask & keep) | wd[NUM_IRQ-1:0];
  assign edge_nxt = (edge_mode & keep) |
                    wd[NUM_IRQ-1:0];

  // lowest set index wins
  function automatic logic [3:0] lowest(
    input logic [NUM_IRQ-1:0] v
  );
    lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) lowest = 4'(i);
  endfunction

  logic [NUM_IRQ-1:0] elig;
  logic               any;
  logic [3:0]         nxt_idx;
  logic [5:0]         nxt_vec;
  logic [NUM_IRQ-1:0] win_hot;
  logic               win_ok;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] pend_nxt;

  assign elig    = gen ? (pending & mask) : '0;
  assign any     = |elig;
  assign nxt_idx = lowest(elig);
  assign nxt_vec = vec_base + {2'b00, nxt_idx};
  assign win_hot = NUM_IRQ'(1) << win_idx;
  assign win_ok  = |(elig & win_hot);

  assign ack_clr = (state == REQ && iack) ?
                   (win_hot & edge_mode) : '0;
  assign w1c     = wr_pend ? wd[NUM_IRQ-1:0] : '0;

  // edge bits latch rises, set beats clear;
  // level bits just follow the line
  assign pend_nxt =
    (edge_mode &
     (rise | (pending & ~w1c & ~ack_clr))) |
    (~edge_mode & level);

  // pending register
  always_ff @(posedge input_clock) begin
    if (!in_reset_n) pending <= '0;
    else             pending <= pend_nxt;
  end

  // software-visible configuration registers
  always_ff @(posedge input_clock) begin
    if (!in_reset_n) begin
      mask      <= '0;
      edge_mode <= '0;
      gen       <= 1'b0;
      vec_base  <= VEC_BASE_RST;
    end else begin
      if (wr_mask) mask <= mask_nxt;
      if (wr_edge) edge_mode <= edge_nxt;
      if (wr_ctrl) begin
        vec_base <= wd[5:0];
        if (word) gen <= wd[GEN_BIT];
      end
    end
  end

  // request / acknowledge handshake with the core
  always_ff @(posedge input_clock) begin
    if (!in_reset_n) begin
      state   <= IDLE;
      win_idx <= '0;
      vec_q   <= VEC_BASE_RST;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state   <= REQ;
            win_idx <= nxt_idx;
            vec_q   <= nxt_vec;
          end
        end
        REQ: begin
          if (iack)        state <= ACK;
          else if (!win_ok) state <= IDLE;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign irq     = (state == REQ);
  assign int_vec = vec_q;

  logic [15:0] rd;

  // combinational register read mux
  always_comb begin
    rd = '0;
    case (reg_sel)
      REG_PENDING: rd = 16'(pending);
      REG_MASK:    rd = 16'(mask);
      REG_EDGE:    rd = 16'(edge_mode);
      REG_CTRL:    rd = {gen, 9'd0, vec_base};
      default:     rd = '0;
    endcase
  end

  assign rdata = (sel & read) ? rd : 16'h0000;

  logic unused;
  assign unused = ^{address[0], wd, be};

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: register table plus
// directed handshake sequences.
module tb_irq_controller;

  import irqc_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  lines;
  logic        irq;
  logic [5:0]  int_vec;
  logic        iack;
  logic [15:0] address;
  logic        mem;
  logic        data;
  logic        read;
  logic        word;
  logic [15:0] wdata;
  logic [15:0] rdata;

  always #5 clk = ~clk;

  irq_controller #(
    .NUM_IRQ      (8),
    .BASE_ADDR    (16'hFF00),
    .VEC_BASE_RST (6'h10)
  ) dut (
    .input_clock (clk),
    .in_reset_n  (rst_n),
    .irq_lines   (lines),
    .irq         (irq),
    .int_vec     (int_vec),
    .iack        (iack),
    .address     (address),
    .mem         (mem),
    .data        (data),
    .read        (read),
    .word        (word),
    .wdata       (wdata),
    .rdata       (rdata)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  r;
    logic        word;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r,
                    input logic [15:0] d,
                    input logic w);
    mem = 1; data = 1; read = 0; word = w;
    address = BASE | {13'd0, r, 1'b0};
    wdata = d;
    tick();
    mem = 0; data = 0; word = 1; wdata = 0;
  endtask

  task automatic rd(input logic [1:0] r,
                    output logic [15:0] d);
    mem = 1; data = 1; read = 1;
    address = BASE | {13'd0, r, 1'b0};
    #1;
    d = rdata;
    mem = 0; data = 0; read = 0;
  endtask

  task automatic chk_rd(input string name,
                        input logic [1:0] r,
                        input logic [15:0] exp);
    logic [15:0] v;
    rd(r, v);
    check(name, v, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    lines = lines | m;
    tick();
    lines = lines & ~m;
  endtask

  task automatic ack();
    iack = 1;
    tick();
    iack = 0;
  endtask

  task automatic wait_req(input string name,
                          input logic [5:0] v);
    tick();
    tick();
    check({name, "_early"}, 16'(irq), 16'd0);
    tick();
    check({name, "_irq"}, 16'(irq), 16'd1);
    check({name, "_vec"}, 16'(int_vec), 16'(v));
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 0; lines = 0; iack = 0;
    address = 0; mem = 0; data = 0;
    read = 0; word = 1; wdata = 0;

    tbl[0]  = '{1'b0, REG_PENDING, 1'b1, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, REG_MASK,    1'b1, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, REG_EDGE,    1'b1, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, REG_CTRL,    1'b1, 16'h0000, 16'h0010};
    tbl[4]  = '{1'b1, REG_MASK,    1'b1, 16'hFFFF, 16'h00FF};
    tbl[5]  = '{1'b1, REG_MASK,    1'b0, 16'h1234, 16'h0034};
    tbl[6]  = '{1'b1, REG_EDGE,    1'b1, 16'hA5A5, 16'h00A5};
    tbl[7]  = '{1'b1, REG_CTRL,    1'b1, 16'h803F, 16'h803F};
    tbl[8]  = '{1'b1, REG_CTRL,    1'b0, 16'h0011, 16'h8011};
    tbl[9]  = '{1'b1, REG_CTRL,    1'b1, 16'h7FFF, 16'h003F};
    tbl[10] = '{1'b1, REG_PENDING, 1'b1, 16'hFFFF, 16'h0000};
    tbl[11] = '{1'b1, REG_CTRL,    1'b1, 16'h0010, 16'h0010};
    tbl[12] = '{1'b1, REG_MASK,    1'b1, 16'h0000, 16'h0000};
    tbl[13] = '{1'b1, REG_EDGE,    1'b1, 16'h0000, 16'h0000};

    repeat (3) tick();
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_vec", 16'(int_vec), 16'h0010);
    check("rst_rdata", rdata, 16'h0000);
    rst_n = 1;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) wr(tbl[i].r, tbl[i].wd, tbl[i].word);
      rd(tbl[i].r, v);
      check($sformatf("tbl%0d", i), v, tbl[i].exp);
      tick();
    end

    // decode corner cases
    mem = 1; data = 1; read = 1;
    address = BASE | 16'h0003;
    wdata = 0;
    wr(REG_MASK, 16'h00C3, 1'b1);
    mem = 1; data = 1; read = 1;
    address = BASE | 16'h0003;
    #1;
    check("odd_addr", rdata, 16'h00C3);
    mem = 0;
    #1;
    check("unsel_rd", rdata, 16'h0000);
    read = 0; data = 0;
    mem = 1; data = 1; address = 16'hFE02;
    wdata = 16'h00FF;
    tick();
    mem = 0; data = 0;
    chk_rd("wrong_base", REG_MASK, 16'h00C3);

    // single edge request and acknowledge
    wr(REG_MASK, 16'h0005, 1'b1);
    wr(REG_EDGE, 16'h0001, 1'b1);
    wr(REG_CTRL, 16'h8010, 1'b1);
    pulse(8'h01);
    wait_req("l0", 6'h10);
    ack();
    check("l0_ack_irq", 16'(irq), 16'd0);
    tick();
    check("l0_idle_irq", 16'(irq), 16'd0);
    chk_rd("l0_pend", REG_PENDING, 16'h0000);

    // two edges together: priority
    wr(REG_EDGE, 16'h0005, 1'b1);
    pulse(8'h05);
    wait_req("l02", 6'h10);
    chk_rd("l02_pend", REG_PENDING, 16'h0005);
    ack();
    check("l02_ack", 16'(irq), 16'd0);
    tick();
    check("l02_gap", 16'(irq), 16'd0);
    tick();
    check("l2_irq", 16'(irq), 16'd1);
    check("l2_vec", 16'(int_vec), 16'h0012);
    ack();
    tick();
    tick();
    chk_rd("l2_pend", REG_PENDING, 16'h0000);
    check("l2_done", 16'(irq), 16'd0);

    // vector wrap and no pre-emption
    wr(REG_CTRL, 16'h803E, 1'b1);
    wr(REG_MASK, 16'h000F, 1'b1);
    wr(REG_EDGE, 16'h000F, 1'b1);
    pulse(8'h08);
    wait_req("l3", 6'h01);
    pulse(8'h01);
    repeat (3) tick();
    check("hold_irq", 16'(irq), 16'd1);
    check("hold_vec", 16'(int_vec), 16'h0001);
    chk_rd("hold_pend", REG_PENDING, 16'h0009);
    ack();
    tick();
    tick();
    check("l0b_irq", 16'(irq), 16'd1);
    check("l0b_vec", 16'(int_vec), 16'h003E);
    ack();
    tick();

    // W1C racing a new edge, then plain W1C
    wr(REG_CTRL, 16'h8010, 1'b1);
    pulse(8'h01);
    wait_req("race", 6'h10);
    pulse(8'h01);
    tick();
    wr(REG_PENDING, 16'h0001, 1'b1);
    chk_rd("race_pend", REG_PENDING, 16'h0001);
    check("race_irq", 16'(irq), 16'd1);
    tick();
    wr(REG_PENDING, 16'h0001, 1'b1);
    chk_rd("w1c_pend", REG_PENDING, 16'h0000);
    tick();
    check("w1c_irq", 16'(irq), 16'd0);

    // level source
    wr(REG_MASK, 16'h0004, 1'b1);
    wr(REG_EDGE, 16'h0000, 1'b1);
    lines = 8'h04;
    tick();
    wait_req("lvl", 6'h12);
    wr(REG_PENDING, 16'h0004, 1'b1);
    chk_rd("lvl_w1c", REG_PENDING, 16'h0004);
    lines = 8'h00;
    repeat (3) tick();
    check("lvl_hold", 16'(irq), 16'd1);
    tick();
    check("lvl_drop", 16'(irq), 16'd0);

    // reset while requesting
    wr(REG_MASK, 16'h0001, 1'b1);
    wr(REG_EDGE, 16'h0001, 1'b1);
    wr(REG_CTRL, 16'h8020, 1'b1);
    pulse(8'h01);
    wait_req("prerst", 6'h20);
    rst_n = 0;
    tick();
    check("rst2_irq", 16'(irq), 16'd0);
    check("rst2_vec", 16'(int_vec), 16'h0010);
    check("rst2_st", 16'(dut.state), 16'(IDLE));
    chk_rd("rst2_mask", REG_MASK, 16'h0000);
    chk_rd("rst2_pend", REG_PENDING, 16'h0000);
    rst_n = 1;
    tick();
    tick();
    check("rst2_after", 16'(irq), 16'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
